// File: rtl/lookup_bv_table.sv
// -----------------------------------------------------------------------------
// lookup_bv_table
//
// Bit-vector lookup table for one field chunk of the BV packet classifier.
// A KEY_W-bit key selects one of DEPTH = 2**KEY_W entries, each BV_W bits wide
// (one bit per rule).
//
// Two independent ports share the table:
//   * Lookup port: fully pipelined, one key per cycle, fixed latency of two
//     cycles after the sampling edge. A write committed at the same edge that
//     samples the key is forwarded into the result (write-first).
//   * Management port: valid/ready command port with at most one command in
//     flight. It supports READ, WRITE, and atomic read-modify-write SET/CLR, so
//     rule insertion and removal only touch their own bit position.
//
// After reset an optional sweep writes zero to every entry (INIT_CLEAR = 1).
// Commands are held off until the sweep is finished. Lookups are always
// accepted, and during the sweep they see the partially cleared table.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high reset
//   cfg_valid  in   command request
//   cfg_ready  out  command accepted when cfg_valid && cfg_ready
//   cfg_op     in   0 = READ, 1 = WRITE, 2 = SET (old | data), 3 = CLR (old & ~data)
//   cfg_addr   in   entry address
//   cfg_data   in   write data or bit mask
//   rsp_valid  out  one-cycle response pulse
//   rsp_data   out  READ: stored entry, otherwise the value now stored
//   key_valid  in   lookup request
//   key        in   lookup index
//   bv_valid   out  lookup result valid
//   bv         out  lookup result (holds its last value when bv_valid = 0)
//   init_done  out  high once the clearing sweep has completed
// -----------------------------------------------------------------------------
module lookup_bv_table #(
   parameter int unsigned KEY_W      = 9,
   parameter int unsigned BV_W       = 36,
   parameter int unsigned INIT_CLEAR = 1
) (
   input  logic             clk,
   input  logic             reset,
   // management port
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [1:0]       cfg_op,
   input  logic [KEY_W-1:0] cfg_addr,
   input  logic [BV_W-1:0]  cfg_data,
   output logic             rsp_valid,
   output logic [BV_W-1:0]  rsp_data,
   // lookup port
   input  logic             key_valid,
   input  logic [KEY_W-1:0] key,
   output logic             bv_valid,
   output logic [BV_W-1:0]  bv,
   // status
   output logic             init_done
);

   localparam int unsigned DEPTH = 2 ** KEY_W;

   localparam logic [1:0] OpRead  = 2'd0;
   localparam logic [1:0] OpWrite = 2'd1;
   localparam logic [1:0] OpSet   = 2'd2;
   localparam logic [1:0] OpClr   = 2'd3;

   localparam logic [KEY_W-1:0] LastAddr = KEY_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      StInit,
      StIdle,
      StRdWait,
      StRmwRd,
      StRmwWr,
      StResp
   } state_e;

   // ---------------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------------
   logic [BV_W-1:0] mem [DEPTH];

   // Single write port, shared by the clearing sweep, WRITE and the RMW commit.
   logic             mem_we;
   logic [KEY_W-1:0] mem_waddr;
   logic [BV_W-1:0]  mem_wdata;

   // ---------------------------------------------------------------------------
   // Command FSM state
   // ---------------------------------------------------------------------------
   state_e           state_q,     state_d;
   logic [KEY_W-1:0] init_addr_q, init_addr_d;
   logic             init_done_q, init_done_d;
   logic [1:0]       op_q,        op_d;
   logic [KEY_W-1:0] addr_q,      addr_d;
   logic [BV_W-1:0]  data_q,      data_d;
   // Holds the entry read for READ/RMW, then the value to report back.
   logic [BV_W-1:0]  result_q,    result_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [BV_W-1:0]  rsp_data_q,  rsp_data_d;

   logic             cfg_accept;
   logic [BV_W-1:0]  cfg_rd_data;
   logic [BV_W-1:0]  rmw_new;

   assign cfg_ready   = ~reset & (state_q == StIdle) & init_done_q;
   assign cfg_accept  = cfg_valid & cfg_ready;
   assign cfg_rd_data = mem[addr_q];
   assign rmw_new     = (op_q == OpSet) ? (result_q | data_q) : (result_q & ~data_q);

   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      init_done_d = init_done_q;
      op_d        = op_q;
      addr_d      = addr_q;
      data_d      = data_q;
      result_d    = result_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      mem_we      = 1'b0;
      mem_waddr   = addr_q;
      mem_wdata   = result_q;

      unique case (state_q)
         StInit: begin
            mem_we      = 1'b1;
            mem_waddr   = init_addr_q;
            mem_wdata   = '0;
            init_addr_d = init_addr_q + 1'b1;
            if (init_addr_q == LastAddr) begin
               init_done_d = 1'b1;
               state_d     = StIdle;
            end
         end

         StIdle: begin
            // Without a sweep, the table is usable from the first edge out of reset.
            if (!init_done_q) begin
               init_done_d = 1'b1;
            end
            if (cfg_accept) begin
               op_d   = cfg_op;
               addr_d = cfg_addr;
               data_d = cfg_data;
               unique case (cfg_op)
                  OpRead: begin
                     state_d = StRdWait;
                  end
                  OpWrite: begin
                     mem_we    = 1'b1;
                     mem_waddr = cfg_addr;
                     mem_wdata = cfg_data;
                     result_d  = cfg_data;
                     state_d   = StResp;
                  end
                  OpSet, OpClr: begin
                     state_d = StRmwRd;
                  end
                  default: begin
                     state_d = StIdle;
                  end
               endcase
            end
         end

         StRdWait: begin
            result_d = cfg_rd_data;
            state_d  = StResp;
         end

         StRmwRd: begin
            result_d = cfg_rd_data;
            state_d  = StRmwWr;
         end

         StRmwWr: begin
            // A zero mask still rewrites the entry with its unchanged value.
            mem_we    = 1'b1;
            mem_waddr = addr_q;
            mem_wdata = rmw_new;
            result_d  = rmw_new;
            state_d   = StResp;
         end

         StResp: begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = result_q;
            state_d     = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= (INIT_CLEAR != 0) ? StInit : StIdle;
         init_addr_q <= '0;
         init_done_q <= 1'b0;
         op_q        <= OpRead;
         addr_q      <= '0;
         data_q      <= '0;
         result_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
         init_done_q <= init_done_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         result_q    <= result_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // Memory has no reset; an aborted command never reaches the write port.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign init_done = init_done_q;

   // ---------------------------------------------------------------------------
   // Lookup pipeline: sample (with write-first forwarding), delay, output.
   // ---------------------------------------------------------------------------
   logic            s1_valid_q, s1_valid_d;
   logic [BV_W-1:0] s1_data_q,  s1_data_d;
   logic            s2_valid_q, s2_valid_d;
   logic [BV_W-1:0] s2_data_q,  s2_data_d;
   logic            bv_valid_q, bv_valid_d;
   logic [BV_W-1:0] bv_q,       bv_d;

   always_comb begin
      s1_valid_d = key_valid;
      // A write landing at the sampling edge must be visible to this lookup.
      if (mem_we && (mem_waddr == key)) begin
         s1_data_d = mem_wdata;
      end else begin
         s1_data_d = mem[key];
      end
      s2_valid_d = s1_valid_q;
      s2_data_d  = s1_data_q;
      bv_valid_d = s2_valid_q;
      bv_d       = s2_valid_q ? s2_data_q : bv_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         bv_valid_q <= 1'b0;
         bv_q       <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         bv_valid_q <= bv_valid_d;
         bv_q       <= bv_d;
      end
   end

   assign bv_valid = bv_valid_q;
   assign bv       = bv_q;

endmodule

// File: tb/tb_lookup_bv_table.sv
module tb_lookup_bv_table;

   localparam int unsigned KW    = 9;
   localparam int unsigned BW    = 36;
   localparam int unsigned DEPTH = 512;

   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [1:0]    cfg_op;
   logic [KW-1:0] cfg_addr;
   logic [BW-1:0] cfg_data;
   logic          rsp_valid;
   logic [BW-1:0] rsp_data;
   logic          key_valid;
   logic [KW-1:0] key;
   logic          bv_valid;
   logic [BW-1:0] bv;
   logic          init_done;

   int n_tests = 0;
   int n_fail  = 0;

   lookup_bv_table #(
      .KEY_W     (KW),
      .BV_W      (BW),
      .INIT_CLEAR(1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_op   (cfg_op),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .rsp_valid(rsp_valid),
      .rsp_data (rsp_data),
      .key_valid(key_valid),
      .key      (key),
      .bv_valid (bv_valid),
      .bv       (bv),
      .init_done(init_done)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Reference model: table contents plus per-command age counters and a plain
   // two-deep delay line for lookups. exp_* are the expected outputs after
   // each rising edge.
   // ---------------------------------------------------------------------------
   logic [BW-1:0] m_mem [DEPTH];
   bit            m_done;
   int            m_sweep;
   bit            m_busy;
   int            m_age;
   int            m_lat;
   logic [1:0]    m_op;
   logic [KW-1:0] m_addr;
   logic [BW-1:0] m_val;
   bit            m_acc;
   bit            pv0, pv1;
   logic [BW-1:0] pd0, pd1;

   logic          exp_ready     = 1'b0;
   logic          exp_rsp_valid = 1'b0;
   logic [BW-1:0] exp_rsp_data  = '0;
   logic          exp_bv_valid  = 1'b0;
   logic [BW-1:0] exp_bv        = '0;
   logic          exp_init_done = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_done = 0; m_sweep = 0; m_busy = 0; pv0 = 0; pv1 = 0;
         exp_ready = 0; exp_rsp_valid = 0; exp_rsp_data = '0;
         exp_bv_valid = 0; exp_bv = '0; exp_init_done = 0;
      end else begin
         m_acc = exp_ready && cfg_valid;
         exp_rsp_valid = 0;
         if (!m_done) begin
            m_mem[m_sweep] = '0;
            m_sweep++;
            if (m_sweep == DEPTH) m_done = 1;
         end
         if (m_busy) begin
            m_age++;
            if (m_op[1] && m_age == 2) m_mem[m_addr] = m_val;
            if (m_age == m_lat) begin
               m_busy = 0;
               exp_rsp_valid = 1;
               exp_rsp_data = m_val;
            end
         end
         if (m_acc) begin
            m_busy = 1; m_age = 0; m_op = cfg_op; m_addr = cfg_addr;
            case (cfg_op)
               2'd0: begin m_val = m_mem[cfg_addr]; m_lat = 2; end
               2'd1: begin m_val = cfg_data; m_mem[cfg_addr] = cfg_data; m_lat = 1; end
               2'd2: begin m_val = m_mem[cfg_addr] | cfg_data; m_lat = 3; end
               default: begin m_val = m_mem[cfg_addr] & ~cfg_data; m_lat = 3; end
            endcase
         end
         exp_bv_valid = pv1;
         if (pv1) exp_bv = pd1;
         pv1 = pv0; pd1 = pd0;
         pv0 = key_valid; pd0 = m_mem[key];
         exp_ready = m_done && !m_busy;
         exp_init_done = m_done;
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (no checking inside)
   // ---------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one command; returns response data and edges from accept to response
   // (-1 if no response within the bound).
   task automatic do_cmd(input logic [1:0] op, input logic [KW-1:0] a,
                         input logic [BW-1:0] d, output logic [BW-1:0] rdata,
                         output int lat);
      int w;
      cfg_valid = 1'b1; cfg_op = op; cfg_addr = a; cfg_data = d;
      w = 0;
      while (!cfg_ready && w < 1000) begin
         step();
         w++;
      end
      step();
      cfg_valid = 1'b0;
      cfg_op    = 2'($urandom);
      cfg_addr  = KW'($urandom);
      cfg_data  = BW'({$urandom(), $urandom()});
      lat = 0;
      while (!rsp_valid && lat < 10) begin
         step();
         lat++;
      end
      if (!rsp_valid) lat = -1;
      rdata = rsp_data;
   endtask

   function automatic logic [BW-1:0] stream_val(input int k);
      if (k == 5) return 36'h71;
      if (k == 10) return 36'hABC;
      return '0;
   endfunction

   // ---------------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      int cnt;
      reset = 1'b1; cfg_valid = 1'b0; cfg_op = '0; cfg_addr = '0; cfg_data = '0;
      key_valid = 1'b0; key = '0;
      repeat (3) step();
      n_tests++;
      if (cfg_ready !== 1'b0 || rsp_valid !== 1'b0 || bv_valid !== 1'b0 ||
          init_done !== 1'b0 || bv !== '0 || rsp_data !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: ready=%b rsp_valid=%b bv_valid=%b init_done=%b bv=%h rsp_data=%h, required all zero",
                  cfg_ready, rsp_valid, bv_valid, init_done, bv, rsp_data);
      end
      reset = 1'b0;
      cnt = 0;
      while (!cfg_ready && cnt < 600) begin
         n_tests++;
         if (init_done !== exp_init_done) begin
            n_fail++;
            $display("FAIL sweep_init_done: got %b, required %b at cycle %0d", init_done,
                     exp_init_done, cnt);
         end
         cnt++;
         step();
      end
      n_tests++;
      if (cnt != 512) begin
         n_fail++;
         $display("FAIL sweep_length: cfg_ready low for %0d cycles, required 512", cnt);
      end
      n_tests++;
      if (init_done !== 1'b1) begin
         n_fail++;
         $display("FAIL init_done_after_sweep: got %b, required 1", init_done);
      end
      key_valid = 1'b1; key = 9'h1FF;
      step();
      key_valid = 1'b0;
      step();
      n_tests++;
      if (bv_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL lookup_early: bv_valid=%b one edge early, required 0", bv_valid);
      end
      step();
      n_tests++;
      if (bv_valid !== 1'b1 || bv !== '0) begin
         n_fail++;
         $display("FAIL lookup_1ff: bv_valid=%b bv=%h, required 1 / 0", bv_valid, bv);
      end
      step();
      n_tests++;
      if (bv_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL lookup_pulse: bv_valid=%b, required 0", bv_valid);
      end
   endtask

   task automatic test_write_read();
      logic [BW-1:0] r;
      int lat;
      do_cmd(2'd1, 9'h005, 36'h0_0000_00F0, r, lat);
      n_tests++;
      if (lat != 1 || r !== 36'hF0) begin
         n_fail++;
         $display("FAIL write_rsp: latency %0d data %h, required 1 / f0", lat, r);
      end
      n_tests++;
      if (cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL write_ready_with_rsp: cfg_ready=%b, required 1", cfg_ready);
      end
      step();
      n_tests++;
      if (rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rsp_pulse_width: rsp_valid=%b, required 0", rsp_valid);
      end
      do_cmd(2'd0, 9'h005, 36'h0, r, lat);
      n_tests++;
      if (lat != 2 || r !== 36'hF0) begin
         n_fail++;
         $display("FAIL read_rsp: latency %0d data %h, required 2 / f0", lat, r);
      end
   endtask

   task automatic test_rmw();
      logic [BW-1:0] r;
      int lat;
      do_cmd(2'd2, 9'h005, 36'h1, r, lat);
      n_tests++;
      if (lat != 3 || r !== 36'hF1) begin
         n_fail++;
         $display("FAIL set_rsp: latency %0d data %h, required 3 / f1", lat, r);
      end
      do_cmd(2'd3, 9'h005, 36'h80, r, lat);
      n_tests++;
      if (lat != 3 || r !== 36'h71) begin
         n_fail++;
         $display("FAIL clr_rsp: latency %0d data %h, required 3 / 71", lat, r);
      end
      do_cmd(2'd2, 9'h005, 36'h0, r, lat);
      n_tests++;
      if (lat != 3 || r !== 36'h71) begin
         n_fail++;
         $display("FAIL set_zero_mask: latency %0d data %h, required 3 / 71", lat, r);
      end
      key_valid = 1'b1; key = 9'h005;
      step();
      key_valid = 1'b0;
      step();
      step();
      n_tests++;
      if (bv_valid !== 1'b1 || bv !== 36'h71) begin
         n_fail++;
         $display("FAIL lookup_after_rmw: bv_valid=%b bv=%h, required 1 / 71", bv_valid, bv);
      end
   endtask

   task automatic test_bypass_stream();
      int run;
      n_tests++;
      if (cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bypass_ready: cfg_ready=%b, required 1", cfg_ready);
      end
      cfg_valid = 1'b1; cfg_op = 2'd1; cfg_addr = 9'h00A; cfg_data = 36'hABC;
      key_valid = 1'b1; key = 9'h00A;
      step();
      cfg_valid = 1'b0; key_valid = 1'b0;
      step();
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== 36'hABC) begin
         n_fail++;
         $display("FAIL bypass_write_rsp: rsp_valid=%b data=%h, required 1 / abc", rsp_valid,
                  rsp_data);
      end
      step();
      n_tests++;
      if (bv_valid !== 1'b1 || bv !== 36'hABC) begin
         n_fail++;
         $display("FAIL bypass_lookup: bv_valid=%b bv=%h, required 1 / abc", bv_valid, bv);
      end
      run = 0;
      for (int c = 0; c < 19; c++) begin
         key_valid = (c < 16);
         key = KW'(c);
         step();
         if (c >= 2 && c < 18) begin
            n_tests++;
            if (bv_valid !== 1'b1 || bv !== stream_val(c - 2)) begin
               n_fail++;
               $display("FAIL stream_key%0d: bv_valid=%b bv=%h, required 1 / %h", c - 2,
                        bv_valid, bv, stream_val(c - 2));
            end else begin
               run++;
            end
         end
      end
      n_tests++;
      if (bv_valid !== 1'b0 || bv !== stream_val(15) || run != 16) begin
         n_fail++;
         $display("FAIL stream_end: bv_valid=%b bv=%h run=%0d, required 0 / held / 16",
                  bv_valid, bv, run);
      end
   endtask

   task automatic test_back_to_back();
      int acc_cycle;
      int pulses;
      logic [BW-1:0] d0, d1;
      bit drop;
      cfg_valid = 1'b1; cfg_op = 2'd2; cfg_addr = 9'h020; cfg_data = 36'h3;
      step();
      cfg_op = 2'd0;
      acc_cycle = -1; pulses = 0; d0 = '1; d1 = '1;
      for (int c = 0; c < 10; c++) begin
         drop = 0;
         if (rsp_valid) begin
            if (pulses == 0) d0 = rsp_data; else d1 = rsp_data;
            pulses++;
         end
         if (cfg_valid && cfg_ready) begin
            if (acc_cycle < 0) acc_cycle = c;
            n_tests++;
            if (rsp_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL accept_with_rsp: rsp_valid=%b at second accept, required 1",
                        rsp_valid);
            end
            drop = 1;
         end
         step();
         if (drop) cfg_valid = 1'b0;
      end
      cfg_valid = 1'b0;
      n_tests++;
      if (acc_cycle != 3 || pulses != 2) begin
         n_fail++;
         $display("FAIL held_valid: second accept at %0d, pulses %0d, required 3 / 2",
                  acc_cycle, pulses);
      end
      n_tests++;
      if (d0 !== 36'h3 || d1 !== 36'h3) begin
         n_fail++;
         $display("FAIL held_valid_data: %h %h, required 3 3", d0, d1);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         n_tests++;
         if (cfg_ready !== exp_ready || rsp_valid !== exp_rsp_valid ||
             bv_valid !== exp_bv_valid) begin
            n_fail++;
            $display("FAIL rand_ctrl c=%0d: ready/rsp/bv_valid=%b%b%b, required %b%b%b", c,
                     cfg_ready, rsp_valid, bv_valid, exp_ready, exp_rsp_valid, exp_bv_valid);
         end
         if (exp_rsp_valid) begin
            n_tests++;
            if (rsp_data !== exp_rsp_data) begin
               n_fail++;
               $display("FAIL rand_rsp c=%0d: got %h, required %h", c, rsp_data, exp_rsp_data);
            end
         end
         if (exp_bv_valid) begin
            n_tests++;
            if (bv !== exp_bv) begin
               n_fail++;
               $display("FAIL rand_bv c=%0d: got %h, required %h", c, bv, exp_bv);
            end
         end
         cfg_valid = ($urandom_range(0, 2) != 0);
         cfg_op    = 2'($urandom);
         cfg_addr  = KW'($urandom_range(0, 15));
         cfg_data  = BW'({$urandom(), $urandom()});
         key_valid = ($urandom_range(0, 3) != 0);
         key       = KW'($urandom_range(0, 15));
         step();
      end
      cfg_valid = 1'b0; key_valid = 1'b0;
      repeat (5) step();
   endtask

   task automatic test_reset_mid_rmw();
      logic [BW-1:0] r;
      int lat;
      int cnt;
      int rsp_seen;
      do_cmd(2'd1, 9'h1F0, 36'h1_2345_6789, r, lat);
      step();
      cfg_valid = 1'b1; cfg_op = 2'd2; cfg_addr = 9'h1F0; cfg_data = 36'hF_0000_0000;
      step();
      cfg_valid = 1'b0;
      reset = 1'b1;
      step();
      n_tests++;
      if (rsp_valid !== 1'b0 || cfg_ready !== 1'b0 || init_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_abort: rsp_valid=%b ready=%b init_done=%b, required 0 0 0",
                  rsp_valid, cfg_ready, init_done);
      end
      reset = 1'b0;
      key_valid = 1'b1; key = 9'h1F0;
      cnt = 0; rsp_seen = 0;
      while (!cfg_ready && cnt < 600) begin
         if (rsp_valid) rsp_seen++;
         if (cnt == 3) begin
            n_tests++;
            if (bv_valid !== 1'b1 || bv !== 36'h1_2345_6789) begin
               n_fail++;
               $display("FAIL rmw_aborted_entry: bv_valid=%b bv=%h, required 1 / 123456789",
                        bv_valid, bv);
            end
         end
         cnt++;
         step();
         key_valid = 1'b0;
      end
      n_tests++;
      if (cnt != 512 || rsp_seen != 0) begin
         n_fail++;
         $display("FAIL resweep: %0d cycles, %0d responses, required 512 / 0", cnt, rsp_seen);
      end
      key_valid = 1'b1; key = 9'h1F0;
      step();
      key_valid = 1'b0;
      step();
      step();
      n_tests++;
      if (bv_valid !== 1'b1 || bv !== '0) begin
         n_fail++;
         $display("FAIL resweep_cleared: bv_valid=%b bv=%h, required 1 / 0", bv_valid, bv);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_rmw();
      test_bypass_stream();
      test_back_to_back();
      test_random();
      test_reset_mid_rmw();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
